// File: rtl/my_bus_if.sv
// myBus command/response wiring between a bus agent (master) and the myBus fabric (slave).
interface my_bus_if;
  logic [2:0] bus_mode_o;
  logic [7:0] bus_addr_o;
  logic [7:0] bus_data_o;
  logic       bus_sel_o;
  logic [2:0] bus_mode_i;
  logic [7:0] bus_addr_i;
  logic [7:0] bus_data_i;
  logic       bus_sel_i;

  modport master (
    output bus_mode_o, bus_addr_o, bus_data_o, bus_sel_o,
    input  bus_mode_i, bus_addr_i, bus_data_i, bus_sel_i
  );

  modport slave (
    input  bus_mode_o, bus_addr_o, bus_data_o, bus_sel_o,
    output bus_mode_i, bus_addr_i, bus_data_i, bus_sel_i
  );
endinterface

// File: rtl/my_bus_master.sv
// myBus agent: queues host commands, issues wr/rd beats, and answers vdo/smap requests with bursts.
// state   | meaning
// IDLE    | arbitrate vdo > smap > FIFO; issues first burst beat or a wr/rd beat
// VDO     | remaining vdoResp beats; SMAP: remaining smapResp beats
// RD_WAIT | waiting for rdResp or timeout
module my_bus_master #(
  parameter int FIFO_DEPTH = 4,
  parameter int VDO_BEATS  = 8,
  parameter int SMAP_BEATS = 4,
  parameter int RD_TIMEOUT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rd,
  input  logic [7:0] cmd_addr,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_err,
  output logic [7:0] ovr_cnt,
  my_bus_if.master   bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TMO_W = $clog2(RD_TIMEOUT);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] VDO     = 2'd1;
  localparam logic [1:0] SMAP    = 2'd2;
  localparam logic [1:0] RD_WAIT = 2'd3;

  localparam logic [2:0] M_WR    = 3'b000;
  localparam logic [2:0] M_RD    = 3'b001;
  localparam logic [2:0] M_RRESP = 3'b010;
  localparam logic [2:0] M_VREQ  = 3'b011;
  localparam logic [2:0] M_VRESP = 3'b100;
  localparam logic [2:0] M_SREQ  = 3'b101;
  localparam logic [2:0] M_SRESP = 3'b110;

  logic [1:0]       state;
  logic [7:0]       beat, vdoSeq, smapSeq;
  logic [TMO_W-1:0] tmo;
  logic             vdoPend, smapPend, vdoClr, smapClr;
  logic             vdoReq, smapReq, rdResp;

  logic [16:0]      fifoMem [FIFO_DEPTH];
  logic [PTR_W-1:0] wrPtr, rdPtr;
  logic [CNT_W-1:0] fifoCnt;
  logic             full, empty, enq, deq;
  logic             hRd;
  logic [7:0]       hAddr, hData;
  logic             unusedAddr;

  assign unusedAddr = ^bus.bus_addr_i;

  assign vdoReq  = bus.bus_sel_i && (bus.bus_mode_i == M_VREQ);
  assign smapReq = bus.bus_sel_i && (bus.bus_mode_i == M_SREQ);
  assign rdResp  = bus.bus_sel_i && (bus.bus_mode_i == M_RRESP);

  assign full      = (fifoCnt == CNT_W'(FIFO_DEPTH));
  assign empty     = (fifoCnt == '0);
  assign cmd_ready = !full && !rst;
  assign enq       = cmd_valid && cmd_ready;
  assign {hRd, hAddr, hData} = fifoMem[rdPtr];

  assign vdoClr  = (state == IDLE) && vdoPend;
  assign smapClr = (state == IDLE) && !vdoPend && smapPend;
  assign deq     = (state == IDLE) && !vdoPend && !smapPend && !empty;

  always_ff @(posedge clk) begin
    if (enq) fifoMem[wrPtr] <= {cmd_rd, cmd_addr, cmd_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr   <= '0;
      rdPtr   <= '0;
      fifoCnt <= '0;
    end else begin
      if (enq) wrPtr <= wrPtr + 1'b1;
      if (deq) rdPtr <= rdPtr + 1'b1;
      case ({enq, deq})
        2'b10:   fifoCnt <= fifoCnt + 1'b1;
        2'b01:   fifoCnt <= fifoCnt - 1'b1;
        default: ;
      endcase
    end
  end

  // A request landing on the cycle its flag clears keeps the flag set, so it is not counted as lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      vdoPend  <= 1'b0;
      smapPend <= 1'b0;
      ovr_cnt  <= 8'd0;
    end else begin
      if (vdoReq) vdoPend <= 1'b1;
      else if (vdoClr) vdoPend <= 1'b0;
      if (smapReq) smapPend <= 1'b1;
      else if (smapClr) smapPend <= 1'b0;
      if (((vdoReq && vdoPend && !vdoClr) || (smapReq && smapPend && !smapClr)) && ovr_cnt != 8'hFF)
        ovr_cnt <= ovr_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      beat           <= 8'd0;
      tmo            <= '0;
      vdoSeq         <= 8'd0;
      smapSeq        <= 8'd0;
      bus.bus_mode_o <= 3'd0;
      bus.bus_addr_o <= 8'd0;
      bus.bus_data_o <= 8'd0;
      bus.bus_sel_o  <= 1'b0;
      rsp_valid      <= 1'b0;
      rsp_err        <= 1'b0;
      rsp_data       <= 8'd0;
    end else begin
      bus.bus_sel_o <= 1'b0;
      rsp_valid     <= 1'b0;
      case (state)
        IDLE: begin
          // The first burst beat goes out on the arbitration cycle so bursts chain without gaps.
          if (vdoPend) begin
            bus.bus_sel_o  <= 1'b1;
            bus.bus_mode_o <= M_VRESP;
            bus.bus_addr_o <= 8'd0;
            bus.bus_data_o <= vdoSeq;
            vdoSeq         <= vdoSeq + 1'b1;
            beat           <= 8'd1;
            if (VDO_BEATS > 1) state <= VDO;
          end else if (smapPend) begin
            bus.bus_sel_o  <= 1'b1;
            bus.bus_mode_o <= M_SRESP;
            bus.bus_addr_o <= 8'd0;
            bus.bus_data_o <= smapSeq;
            smapSeq        <= smapSeq + 1'b1;
            beat           <= 8'd1;
            if (SMAP_BEATS > 1) state <= SMAP;
          end else if (!empty) begin
            bus.bus_sel_o  <= 1'b1;
            bus.bus_addr_o <= hAddr;
            if (hRd) begin
              bus.bus_mode_o <= M_RD;
              bus.bus_data_o <= 8'd0;
              tmo            <= TMO_W'(RD_TIMEOUT - 1);
              state          <= RD_WAIT;
            end else begin
              bus.bus_mode_o <= M_WR;
              bus.bus_data_o <= hData;
            end
          end
        end
        VDO: begin
          bus.bus_sel_o  <= 1'b1;
          bus.bus_mode_o <= M_VRESP;
          bus.bus_addr_o <= beat;
          bus.bus_data_o <= vdoSeq;
          vdoSeq         <= vdoSeq + 1'b1;
          beat           <= beat + 1'b1;
          if (beat == 8'(VDO_BEATS - 1)) state <= IDLE;
        end
        SMAP: begin
          bus.bus_sel_o  <= 1'b1;
          bus.bus_mode_o <= M_SRESP;
          bus.bus_addr_o <= beat;
          bus.bus_data_o <= smapSeq;
          smapSeq        <= smapSeq + 1'b1;
          beat           <= beat + 1'b1;
          if (beat == 8'(SMAP_BEATS - 1)) state <= IDLE;
        end
        RD_WAIT: begin
          tmo <= tmo - 1'b1;
          if (rdResp) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_data  <= bus.bus_data_i;
            state     <= IDLE;
          end else if (tmo == '0) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_data  <= 8'd0;
            state     <= IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_my_bus_master.sv
// Scoreboard bench for my_bus_master: directed stimulus pushes expected beats/responses, a monitor pops and compares.
module tb_my_bus_master;
  localparam int RD_TIMEOUT = 8;

  typedef struct {
    logic [2:0] mode;
    logic [7:0] addr;
    logic [7:0] data;
    bit         contig;
  } beatT;

  typedef struct {
    logic [7:0] data;
    logic       err;
    int         lat;
    bit         exact;
  } rspT;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmdValid = 1'b0, cmdRd = 1'b0;
  logic [7:0] cmdAddr = 8'd0, cmdData = 8'd0;
  logic       cmdReady, rspValid, rspErr;
  logic [7:0] rspData, ovrCnt;
  logic       stimSel = 1'b0, respSel = 1'b0, respOn = 1'b0;
  logic [2:0] stimMode = 3'd0;
  logic [7:0] respData = 8'd0, rdA;
  logic [7:0] slvMem [256];

  beatT expBeats[$];
  rspT  expRsp[$];
  int   vectors = 0, miscompares = 0;
  int   cyc = 0, lastBeatCyc = -10, lastRdCyc = 0;
  int   accepted, dropAt;

  my_bus_if bif();
  assign bif.bus_sel_i  = stimSel | respSel;
  assign bif.bus_mode_i = respSel ? 3'b010 : stimMode;
  assign bif.bus_data_i = respSel ? respData : 8'h00;
  assign bif.bus_addr_i = 8'h00;

  my_bus_master #(.FIFO_DEPTH(4), .VDO_BEATS(8), .SMAP_BEATS(4), .RD_TIMEOUT(RD_TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmdValid), .cmd_ready(cmdReady), .cmd_rd(cmdRd),
    .cmd_addr(cmdAddr), .cmd_data(cmdData),
    .rsp_valid(rspValid), .rsp_data(rspData), .rsp_err(rspErr),
    .ovr_cnt(ovrCnt), .bus(bif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Monitor: every presented beat and response is popped against the scoreboard.
  always @(negedge clk) begin
    if (bif.bus_sel_o) begin
      vectors++;
      if (expBeats.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_beat got mode=%0h addr=%0h data=%0h, expected none",
                 bif.bus_mode_o, bif.bus_addr_o, bif.bus_data_o);
      end else begin
        beatT e;
        e = expBeats.pop_front();
        if (bif.bus_mode_o !== e.mode || bif.bus_addr_o !== e.addr || bif.bus_data_o !== e.data) begin
          miscompares++;
          $display("FAIL beat got mode=%0h addr=%0h data=%0h, expected mode=%0h addr=%0h data=%0h",
                   bif.bus_mode_o, bif.bus_addr_o, bif.bus_data_o, e.mode, e.addr, e.data);
        end else if (e.contig && cyc != lastBeatCyc + 1) begin
          miscompares++;
          $display("FAIL beat_gap got gap=%0d cycles, expected 1", cyc - lastBeatCyc);
        end
      end
      lastBeatCyc = cyc;
      if (bif.bus_mode_o == 3'b000) slvMem[bif.bus_addr_o] = bif.bus_data_o;
      if (bif.bus_mode_o == 3'b001) lastRdCyc = cyc;
    end
    if (rspValid) begin
      vectors++;
      if (expRsp.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_rsp got data=%0h err=%0b, expected none", rspData, rspErr);
      end else begin
        rspT r;
        r = expRsp.pop_front();
        if (rspData !== r.data || rspErr !== r.err) begin
          miscompares++;
          $display("FAIL rsp got data=%0h err=%0b, expected data=%0h err=%0b", rspData, rspErr, r.data, r.err);
        end else if (r.exact ? (cyc - lastRdCyc != r.lat) : (cyc - lastRdCyc > r.lat)) begin
          miscompares++;
          $display("FAIL rsp_latency got %0d cycles, expected %s%0d", cyc - lastRdCyc, r.exact ? "" : "<=", r.lat);
        end
      end
    end
  end

  // myBus read slave: answers an rdCmd two cycles later from memory built from observed writes.
  initial begin
    forever begin
      @(negedge clk);
      if (respOn && bif.bus_sel_o && bif.bus_mode_o == 3'b001) begin
        rdA = bif.bus_addr_o;
        @(posedge clk);
        @(posedge clk);
        #1 respSel = 1'b1;
        respData = slvMem[rdA];
        @(posedge clk);
        #1 respSel = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got time limit, expected $finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushBeat(input logic [2:0] m, input logic [7:0] a, input logic [7:0] d, input bit contig);
    beatT e;
    e.mode = m; e.addr = a; e.data = d; e.contig = contig;
    expBeats.push_back(e);
  endtask

  task automatic pushBurst(input logic [2:0] m, input int n, input int seq0, input bit firstContig);
    for (int i = 0; i < n; i++) pushBeat(m, 8'(i), 8'(seq0 + i), (i > 0) || firstContig);
  endtask

  task automatic pushRsp(input logic [7:0] d, input logic err, input int lat, input bit exact);
    rspT r;
    r.data = d; r.err = err; r.lat = lat; r.exact = exact;
    expRsp.push_back(r);
  endtask

  task automatic busReq(input logic [2:0] m);
    stimSel = 1'b1;
    stimMode = m;
    tick();
    stimSel = 1'b0;
    stimMode = 3'd0;
  endtask

  task automatic hostCmd(input logic rd, input logic [7:0] a, input logic [7:0] d);
    cmdValid = 1'b1; cmdRd = rd; cmdAddr = a; cmdData = d;
    for (int i = 0; i < 50; i++) begin
      if (cmdReady) begin
        tick();
        cmdValid = 1'b0;
        return;
      end
      tick();
    end
    cmdValid = 1'b0;
    vectors++;
    miscompares++;
    $display("FAIL cmd_accept got no cmd_ready in 50 cycles, expected acceptance");
  endtask

  task automatic waitQuiet(input int n);
    for (int i = 0; i < n; i++) begin
      if (expBeats.size() == 0 && expRsp.size() == 0) break;
      tick();
    end
    vectors++;
    if (expBeats.size() != 0 || expRsp.size() != 0) begin
      miscompares++;
      $display("FAIL drain got %0d beats %0d rsps outstanding, expected 0 0", expBeats.size(), expRsp.size());
    end
    repeat (3) tick();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) slvMem[i] = 8'h00;
    repeat (3) tick();
    check("rst_sel", bif.bus_sel_o, 0);
    check("rst_mode", bif.bus_mode_o, 0);
    check("rst_addr", bif.bus_addr_o, 0);
    check("rst_data", bif.bus_data_o, 0);
    check("rst_rsp", {rspValid, rspErr, rspData}, 0);
    check("rst_ovr", ovrCnt, 0);
    check("rst_ready", cmdReady, 0);
    rst = 1'b0;
    tick();
    check("ready_after_rst", cmdReady, 1);

    // write then read back
    respOn = 1'b1;
    pushBeat(3'b000, 8'h12, 8'hA5, 1'b0);
    pushBeat(3'b001, 8'h12, 8'h00, 1'b1);
    pushRsp(8'hA5, 1'b0, 4, 1'b0);
    hostCmd(1'b0, 8'h12, 8'hA5);
    hostCmd(1'b1, 8'h12, 8'h00);
    waitQuiet(40);

    // two video bursts, sequence continues across bursts
    pushBurst(3'b100, 8, 0, 1'b0);
    busReq(3'b011);
    waitQuiet(40);
    pushBurst(3'b100, 8, 8, 1'b0);
    busReq(3'b011);
    waitQuiet(40);

    // priority: vdo > smap > queued writes, chained without gaps
    pushBurst(3'b100, 8, 16, 1'b0);
    pushBurst(3'b110, 4, 0, 1'b1);
    pushBeat(3'b000, 8'h30, 8'hC1, 1'b1);
    pushBeat(3'b000, 8'h31, 8'hC2, 1'b1);
    stimSel = 1'b1; stimMode = 3'b011;
    cmdValid = 1'b1; cmdRd = 1'b0; cmdAddr = 8'h30; cmdData = 8'hC1;
    tick();
    stimMode = 3'b101; cmdAddr = 8'h31; cmdData = 8'hC2;
    tick();
    stimSel = 1'b0; stimMode = 3'd0; cmdValid = 1'b0;
    waitQuiet(60);
    check("ovr_none_yet", ovrCnt, 0);

    // read timeout, stray rdResp ignored, FSM back in IDLE
    respOn = 1'b0;
    pushBeat(3'b001, 8'h40, 8'h00, 1'b0);
    pushRsp(8'h00, 1'b1, RD_TIMEOUT, 1'b1);
    hostCmd(1'b1, 8'h40, 8'h00);
    waitQuiet(40);
    busReq(3'b010);
    pushBeat(3'b000, 8'h41, 8'h5A, 1'b0);
    hostCmd(1'b0, 8'h41, 8'h5A);
    waitQuiet(40);

    // FIFO fills during a burst; six writes drain in order afterwards
    pushBurst(3'b100, 8, 24, 1'b0);
    for (int i = 0; i < 6; i++) pushBeat(3'b000, 8'(8'h50 + i), 8'(8'h60 + i), 1'b1);
    busReq(3'b011);
    accepted = 0;
    dropAt = -1;
    cmdValid = 1'b1; cmdRd = 1'b0;
    for (int i = 0; i < 200 && accepted < 6; i++) begin
      cmdAddr = 8'(8'h50 + accepted);
      cmdData = 8'(8'h60 + accepted);
      if (cmdReady) begin
        tick();
        accepted++;
      end else begin
        if (dropAt < 0) dropAt = accepted;
        tick();
      end
    end
    cmdValid = 1'b0;
    check("fifo_full_drop", dropAt, 4);
    check("fifo_accepted", accepted, 6);
    waitQuiet(60);

    // three requests within one burst: two coalesce, one extra burst follows
    pushBurst(3'b100, 8, 32, 1'b0);
    pushBurst(3'b100, 8, 40, 1'b1);
    busReq(3'b011);
    for (int i = 0; i < 3; i++) begin
      busReq(3'b011);
      tick();
    end
    waitQuiet(60);
    check("ovr_cnt", ovrCnt, 2);

    // reset mid-burst abandons it and clears everything
    pushBurst(3'b100, 3, 48, 1'b0);
    busReq(3'b011);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    check("midrst_sel", bif.bus_sel_o, 0);
    check("midrst_bus", {bif.bus_mode_o, bif.bus_addr_o, bif.bus_data_o}, 0);
    check("midrst_rsp", {rspValid, rspErr, rspData}, 0);
    check("midrst_ovr", ovrCnt, 0);
    check("midrst_ready", cmdReady, 0);
    tick();
    rst = 1'b0;
    repeat (12) tick();
    check("midrst_no_resume", expBeats.size(), 0);
    pushBurst(3'b100, 8, 0, 1'b0);
    busReq(3'b011);
    waitQuiet(40);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
